pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Parametrised pipeline sequencer and hazard unit for the next-generation core; replaces hard-wired 5-stage hazard logic.
// Tracks per-stage valid/rd/write/load state for EX..WB, drives EX forwarding selects and ID regfile bypass.
// Generates load-use stalls, branch flushes and a global memory-wait freeze. Sits beside the datapath; holds no data values.
// PARAMETERS
// NSTAGES           5  total stages (IF=0, ID=1, EX=EX_STAGE, ..., WB=NSTAGES-1); legal 4..8
// EX_STAGE          2  stage that consumes forwarded operands and resolves branches; legal 2..NSTAGES-2
// LOAD_READY_STAGE  4  first stage where a load result is forwardable; legal EX_STAGE+1..NSTAGES-1
// FW (local)           $clog2(NSTAGES-EX_STAGE), minimum 1: forward-select width
// PORTS
// clk             in   1   clock, rising edge
// rst_n           in   1   synchronous reset, active low
// id_valid        in   1   ID holds a real instruction
// id_rs1/id_rs2   in   5   ID source register indices
// id_use_rs1/2    in   1   ID instruction reads rs1/rs2
// id_rd           in   5   ID destination index
// id_wr           in   1   ID instruction writes rd
// id_is_load      in   1   ID instruction is a load
// ex_redirect     in   1   EX branch/jump taken this cycle
// mem_wait        in   1   data memory not ready; freeze pipeline
// stall_if        out  1   hold PC and IF/ID register
// stall_id        out  1   hold ID contents, insert bubble into EX
// flush_id        out  1   replace IF/ID contents with NOP (0x00000013)
// stage_valid     out  NSTAGES  valid bit per stage (bit 0 = IF, always 1 after reset)
// ex_fwd_rs1/2    out  FW  0 = use ID-read value; k = take result of stage EX_STAGE+k
// id_byp_rs1/2    out  1   ID source matches the register being written by WB this cycle
// wb_en           out  1   regfile write enable (valid & wr & rd!=0 at WB)
// wb_rd           out  5   regfile write index
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all stage entries invalid, rd=0; all outputs 0 except stage_valid[0]=1 on the first cycle after reset.
// - State: per stage s in EX_STAGE..NSTAGES-1 registers {valid, rd, wr, is_load, rs1, rs2, use_rs1, use_rs2}.
// - Advance (mem_wait=0): s+1 <= s for s >= EX_STAGE; EX <= ID fields, or a bubble (valid=0) if stall_id or ex_redirect.
// - Freeze (mem_wait=1): no register changes; stall_if=1; stall_id=0; flush_id=0; ex_redirect ignored (EX is held, so redirect reasserts next cycle).
// - Load-use: stall_id=stall_if=1 when id_valid, a source is used, src!=0, and some stage p with EX_STAGE<=p<=LOAD_READY_STAGE-2 holds a valid load with rd==src.
// - Redirect (mem_wait=0): flush_id=1, stall_if=0, stall_id=0; redirect wins over load-use stall.
// - ex_fwd: compare EX rs1/rs2 (if used, !=0) with stages EX_STAGE+1..NSTAGES-1 (valid & wr); youngest (lowest index) match wins, sel=k; none -> 0.
// - A load in a stage < LOAD_READY_STAGE that matches is impossible by construction; assert in simulation.
// - id_byp: combinational; WB valid & wr & rd!=0 & rd==id_rsX & id_use_rsX.
// - rd==0 never forwards, bypasses or stalls; wb_en=0 for rd==0.
// - All control outputs are combinational from current state and ID inputs; zero latency. Stage state has 1-cycle latency per stage.
// STRUCTURE
// - Package riscv_pipe_pkg: NOP_INSN, stage-index localparams, forward-select encoding, opcode constants shared with control.
// - Sub-module pipe_hazard_cmp: one per stage; match = valid & wr & rd!=0 & rd==src & use; instantiated via generate for rs1 and rs2.
// - Priority encoder for youngest match in pipe_hazard_ctrl; no other hierarchy.
// TESTING (NSTAGES=5, EX_STAGE=2, LOAD_READY_STAGE=4)
// - Reset: hold rst_n=0 for 3 cycles with random inputs -> stage_valid=5'b00001, wb_en=0, all selects 0.
// - ALU chain: add x5 then add x6,x5,x5 back-to-back -> ex_fwd_rs1=ex_fwd_rs2=1 on second instr; no stall.
// - Load-use: lw x7 then add x8,x7,x0 -> stall_id=stall_if=1 for exactly 1 cycle, then ex_fwd_rs1=2.
// - Redirect plus load-use in same cycle -> flush_id=1, stall_id=0; EX valid=0 next cycle.
// - mem_wait high for 4 cycles mid-chain -> stage_valid and wb_rd frozen, stall_if=1, forwarding resumes identically after release.
// - WB bypass: write x9 in WB while ID reads x9 -> id_byp_rs1=1; same with rd=x0 -> id_byp_rs1=0, wb_en=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants: stage indices, forward-select encoding, opcodes
// and the per-stage hazard bookkeeping record.
package riscv_pipe_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int IF_STAGE = 0;
  localparam int ID_STAGE = 1;

  localparam int FWD_NONE = 0;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } stage_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; the datapath is the master,
// the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int FW      = 2
);
  logic               id_valid;
  logic [4:0]         id_rs1;
  logic [4:0]         id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [4:0]         id_rd;
  logic               id_wr;
  logic               id_is_load;
  logic               ex_redirect;
  logic               mem_wait;

  logic               stall_if;
  logic               stall_id;
  logic               flush_id;
  logic [NSTAGES-1:0] stage_valid;
  logic [FW-1:0]      ex_fwd_rs1;
  logic [FW-1:0]      ex_fwd_rs2;
  logic               id_byp_rs1;
  logic               id_byp_rs2;
  logic               wb_en;
  logic [4:0]         wb_rd;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
           id_is_load, ex_redirect, mem_wait,
    input  stall_if, stall_id, flush_id, stage_valid, ex_fwd_rs1, ex_fwd_rs2,
           id_byp_rs1, id_byp_rs2, wb_en, wb_rd
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
           id_is_load, ex_redirect, mem_wait,
    output stall_if, stall_id, flush_id, stage_valid, ex_fwd_rs1, ex_fwd_rs2,
           id_byp_rs1, id_byp_rs2, wb_en, wb_rd
  );
endinterface

// File: rtl/pipe_hazard_ctrl_cmp.sv
// One register-match comparator: a stage entry that will write a non-zero rd
// equal to a source that is actually read.
module pipe_hazard_cmp (
  input  logic       i_valid,
  input  logic       i_wr,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_src,
  input  logic       i_use,
  output logic       o_match
);
  assign o_match = i_valid & i_wr & (i_rd != 5'd0) & (i_rd == i_src) & i_use;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised pipeline sequencer and hazard unit: tracks EX..WB bookkeeping,
// drives forwarding/bypass selects, load-use stalls, flushes and freeze.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int NSTAGES          = 5,
  parameter int EX_STAGE         = 2,
  parameter int LOAD_READY_STAGE = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int LAST = NSTAGES - 1;
  localparam int NFWD = LAST - EX_STAGE;
  localparam int NLU  = LOAD_READY_STAGE - 1 - EX_STAGE;
  localparam int FW   = (NFWD + 1 > 2) ? $clog2(NFWD + 1) : 1;

  stage_t r_stage [EX_STAGE:LAST];

  stage_t             w_id_entry;
  logic [NFWD:1]      w_fwd1, w_fwd2;
  logic [FW-1:0]      w_sel1, w_sel2;
  logic               w_load_use;
  logic               w_stall_if, w_stall_id, w_flush_id;
  logic               w_ld_fwd_bad;
  logic [NSTAGES-1:0] w_stage_valid;
  logic               w_byp1, w_byp2;

  always_comb begin
    w_id_entry = '0;
    if (bus.id_valid) begin
      w_id_entry = '{valid: 1'b1, rd: bus.id_rd, wr: bus.id_wr,
                     is_load: bus.id_is_load, rs1: bus.id_rs1, rs2: bus.id_rs2,
                     use_rs1: bus.id_use_rs1, use_rs2: bus.id_use_rs2};
    end
  end

  for (genvar k = 1; k <= NFWD; k++) begin : g_fwd
    pipe_hazard_cmp u_cmp1 (
      .i_valid(r_stage[EX_STAGE+k].valid), .i_wr(r_stage[EX_STAGE+k].wr),
      .i_rd(r_stage[EX_STAGE+k].rd), .i_src(r_stage[EX_STAGE].rs1),
      .i_use(r_stage[EX_STAGE].use_rs1), .o_match(w_fwd1[k])
    );
    pipe_hazard_cmp u_cmp2 (
      .i_valid(r_stage[EX_STAGE+k].valid), .i_wr(r_stage[EX_STAGE+k].wr),
      .i_rd(r_stage[EX_STAGE+k].rd), .i_src(r_stage[EX_STAGE].rs2),
      .i_use(r_stage[EX_STAGE].use_rs2), .o_match(w_fwd2[k])
    );
  end

  // Loads still short of the ready stage cannot forward, so ID must wait.
  if (NLU > 0) begin : g_lu
    logic [NLU-1:0] w_hit1, w_hit2;
    for (genvar p = 0; p < NLU; p++) begin : g_stage
      pipe_hazard_cmp u_lu1 (
        .i_valid(r_stage[EX_STAGE+p].valid),
        .i_wr(r_stage[EX_STAGE+p].wr & r_stage[EX_STAGE+p].is_load),
        .i_rd(r_stage[EX_STAGE+p].rd), .i_src(bus.id_rs1),
        .i_use(bus.id_use_rs1 & bus.id_valid), .o_match(w_hit1[p])
      );
      pipe_hazard_cmp u_lu2 (
        .i_valid(r_stage[EX_STAGE+p].valid),
        .i_wr(r_stage[EX_STAGE+p].wr & r_stage[EX_STAGE+p].is_load),
        .i_rd(r_stage[EX_STAGE+p].rd), .i_src(bus.id_rs2),
        .i_use(bus.id_use_rs2 & bus.id_valid), .o_match(w_hit2[p])
      );
    end
    assign w_load_use = (|w_hit1) | (|w_hit2);
  end else begin : g_no_lu
    assign w_load_use = 1'b0;
  end

  pipe_hazard_cmp u_byp1 (
    .i_valid(r_stage[LAST].valid), .i_wr(r_stage[LAST].wr), .i_rd(r_stage[LAST].rd),
    .i_src(bus.id_rs1), .i_use(bus.id_use_rs1), .o_match(w_byp1)
  );
  pipe_hazard_cmp u_byp2 (
    .i_valid(r_stage[LAST].valid), .i_wr(r_stage[LAST].wr), .i_rd(r_stage[LAST].rd),
    .i_src(bus.id_rs2), .i_use(bus.id_use_rs2), .o_match(w_byp2)
  );

  // Scan oldest to youngest so the youngest matching stage is left in the select.
  always_comb begin
    w_sel1 = FW'(FWD_NONE);
    w_sel2 = FW'(FWD_NONE);
    for (int k = NFWD; k >= 1; k--) begin
      if (w_fwd1[k]) w_sel1 = FW'(k);
      if (w_fwd2[k]) w_sel2 = FW'(k);
    end
  end

  always_comb begin
    w_ld_fwd_bad = 1'b0;
    for (int k = 1; k <= NFWD; k++) begin
      if ((EX_STAGE + k < LOAD_READY_STAGE) && r_stage[EX_STAGE+k].is_load &&
          (w_fwd1[k] || w_fwd2[k]))
        w_ld_fwd_bad = 1'b1;
    end
  end

  // A freeze overrides everything; a redirect discards ID and so beats load-use.
  always_comb begin
    w_stall_if = 1'b0;
    w_stall_id = 1'b0;
    w_flush_id = 1'b0;
    if (bus.mem_wait) begin
      w_stall_if = 1'b1;
    end else if (bus.ex_redirect) begin
      w_flush_id = 1'b1;
    end else if (w_load_use) begin
      w_stall_if = 1'b1;
      w_stall_id = 1'b1;
    end
  end

  always_comb begin
    w_stage_valid           = '0;
    w_stage_valid[IF_STAGE] = 1'b1;
    w_stage_valid[ID_STAGE] = bus.id_valid;
    for (int s = EX_STAGE; s <= LAST; s++) w_stage_valid[s] = r_stage[s].valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = EX_STAGE; s <= LAST; s++) r_stage[s] <= '0;
    end else if (!bus.mem_wait) begin
      for (int s = LAST; s > EX_STAGE; s--) r_stage[s] <= r_stage[s-1];
      r_stage[EX_STAGE] <= (w_stall_id || bus.ex_redirect) ? '0 : w_id_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!w_ld_fwd_bad);
  end

  assign bus.stall_if    = w_stall_if;
  assign bus.stall_id    = w_stall_id;
  assign bus.flush_id    = w_flush_id;
  assign bus.stage_valid = w_stage_valid;
  assign bus.ex_fwd_rs1  = w_sel1;
  assign bus.ex_fwd_rs2  = w_sel2;
  assign bus.id_byp_rs1  = w_byp1;
  assign bus.id_byp_rs2  = w_byp2;
  assign bus.wb_en       = r_stage[LAST].valid & r_stage[LAST].wr & (r_stage[LAST].rd != 5'd0);
  assign bus.wb_rd       = r_stage[LAST].rd;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenario bench for pipe_hazard_ctrl with NSTAGES=5, EX=2, load ready at 4.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGES(5), .FW(2)) bus ();

  pipe_hazard_ctrl #(.NSTAGES(5), .EX_STAGE(2), .LOAD_READY_STAGE(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    bus.id_valid = v;   bus.id_rs1 = rs1; bus.id_use_rs1 = u1;
    bus.id_rs2 = rs2;   bus.id_use_rs2 = u2;
    bus.id_rd = rd;     bus.id_wr = wr;   bus.id_is_load = ld;
    #1;
  endtask

  task automatic clear_inputs();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.ex_redirect = 1'b0;
    bus.mem_wait = 1'b0;
    #1;
  endtask

  task automatic drain();
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_id(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom));
      bus.ex_redirect = 1'($urandom);
      bus.mem_wait = 1'($urandom);
      tick();
    end
    clear_inputs();
    checks++; if (bus.stage_valid !== 5'b00001) begin failures++; $display("[TB] FAIL reset_stage_valid got=%b exp=%b", bus.stage_valid, 5'b00001); end
    checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_en got=%b exp=0", bus.wb_en); end
    checks++; if ({bus.ex_fwd_rs1, bus.ex_fwd_rs2} !== 4'd0) begin failures++; $display("[TB] FAIL reset_fwd got=%0d/%0d exp=0/0", bus.ex_fwd_rs1, bus.ex_fwd_rs2); end
    checks++; if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.id_byp_rs1, bus.id_byp_rs2} !== 5'd0) begin failures++; $display("[TB] FAIL reset_ctrl got=%b exp=00000", {bus.stall_if, bus.stall_id, bus.flush_id, bus.id_byp_rs1, bus.id_byp_rs2}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("[TB] FAIL alu_no_stall got=%b exp=0", bus.stall_id); end
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++; if (bus.ex_fwd_rs1 !== 2'd1) begin failures++; $display("[TB] FAIL alu_fwd_rs1 got=%0d exp=1", bus.ex_fwd_rs1); end
    checks++; if (bus.ex_fwd_rs2 !== 2'd1) begin failures++; $display("[TB] FAIL alu_fwd_rs2 got=%0d exp=1", bus.ex_fwd_rs2); end
    tick();
    checks++; if (bus.stage_valid !== 5'b11001) begin failures++; $display("[TB] FAIL alu_stage_valid got=%b exp=%b", bus.stage_valid, 5'b11001); end
    checks++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd5) begin failures++; $display("[TB] FAIL alu_wb1 got=%b/%0d exp=1/5", bus.wb_en, bus.wb_rd); end
    tick();
    checks++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd6) begin failures++; $display("[TB] FAIL alu_wb2 got=%b/%0d exp=1/6", bus.wb_en, bus.wb_rd); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    checks++; if (bus.stall_id !== 1'b1 || bus.stall_if !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall got=%b%b exp=11", bus.stall_id, bus.stall_if); end
    tick();
    checks++; if (bus.stall_id !== 1'b0 || bus.stall_if !== 1'b0) begin failures++; $display("[TB] FAIL lu_one_cycle got=%b%b exp=00", bus.stall_id, bus.stall_if); end
    checks++; if (bus.stage_valid[2] !== 1'b0) begin failures++; $display("[TB] FAIL lu_bubble got=%b exp=0", bus.stage_valid[2]); end
    tick();
    checks++; if (bus.ex_fwd_rs1 !== 2'd2) begin failures++; $display("[TB] FAIL lu_fwd_rs1 got=%0d exp=2", bus.ex_fwd_rs1); end
    checks++; if (bus.ex_fwd_rs2 !== 2'd0) begin failures++; $display("[TB] FAIL lu_fwd_x0 got=%0d exp=0", bus.ex_fwd_rs2); end
    drain();
  endtask

  task automatic test_redirect();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    bus.ex_redirect = 1'b1;
    #1;
    checks++; if (bus.flush_id !== 1'b1) begin failures++; $display("[TB] FAIL redir_flush got=%b exp=1", bus.flush_id); end
    checks++; if (bus.stall_id !== 1'b0 || bus.stall_if !== 1'b0) begin failures++; $display("[TB] FAIL redir_nostall got=%b%b exp=00", bus.stall_id, bus.stall_if); end
    tick();
    clear_inputs();
    checks++; if (bus.stage_valid !== 5'b01001) begin failures++; $display("[TB] FAIL redir_ex_bubble got=%b exp=%b", bus.stage_valid, 5'b01001); end
    drain();
  endtask

  task automatic test_mem_wait();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.mem_wait = 1'b1;
    #1;
    checks++; if (bus.stall_if !== 1'b1 || bus.stall_id !== 1'b0) begin failures++; $display("[TB] FAIL mw_stall got=%b%b exp=10", bus.stall_if, bus.stall_id); end
    for (int i = 0; i < 4; i++) begin
      bus.ex_redirect = (i == 1);
      tick();
    end
    bus.ex_redirect = 1'b1;
    #1;
    checks++; if (bus.flush_id !== 1'b0) begin failures++; $display("[TB] FAIL mw_redirect_ignored got=%b exp=0", bus.flush_id); end
    checks++; if (bus.stage_valid !== 5'b01101 || bus.wb_rd !== 5'd0) begin failures++; $display("[TB] FAIL mw_frozen got=%b/%0d exp=%b/0", bus.stage_valid, bus.wb_rd, 5'b01101); end
    checks++; if (bus.ex_fwd_rs1 !== 2'd1) begin failures++; $display("[TB] FAIL mw_fwd_held got=%0d exp=1", bus.ex_fwd_rs1); end
    bus.ex_redirect = 1'b0;
    bus.mem_wait = 1'b0;
    #1;
    checks++; if (bus.stall_if !== 1'b0 || bus.ex_fwd_rs2 !== 2'd1) begin failures++; $display("[TB] FAIL mw_release got=%b/%0d exp=0/1", bus.stall_if, bus.ex_fwd_rs2); end
    tick();
    checks++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd5) begin failures++; $display("[TB] FAIL mw_resume_wb got=%b/%0d exp=1/5", bus.wb_en, bus.wb_rd); end
    drain();
  endtask

  task automatic test_wb_bypass();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
    checks++; if (bus.id_byp_rs1 !== 1'b1 || bus.id_byp_rs2 !== 1'b0) begin failures++; $display("[TB] FAIL byp_x9 got=%b%b exp=10", bus.id_byp_rs1, bus.id_byp_rs2); end
    checks++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd9) begin failures++; $display("[TB] FAIL byp_wb_x9 got=%b/%0d exp=1/9", bus.wb_en, bus.wb_rd); end
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
    checks++; if (bus.id_byp_rs1 !== 1'b0) begin failures++; $display("[TB] FAIL byp_x0 got=%b exp=0", bus.id_byp_rs1); end
    checks++; if (bus.wb_en !== 1'b0 || bus.stage_valid[4] !== 1'b1) begin failures++; $display("[TB] FAIL byp_wb_x0 got=%b/%b exp=0/1", bus.wb_en, bus.stage_valid[4]); end
    drain();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_wb_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
